exec_ctrl: RTL and testbench
============================

# exec_ctrl

Run/halt/step sequencer for the single-cycle core. It drives the core's global clock-enable, so the board or bench can:
- halt the core,
- single-step one instruction,
- run a fixed burst of N instructions,
- free-run until a PC breakpoint.

It sits between the debug inputs (debounced board buttons, or bench stimulus) and the core. It also counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter
- BURST_W, 16, width of the burst length

Ports:
- clk  in  1  system clock, same clock as the core
- rst  in  1  asynchronous, active-high reset
- run_req  in  1  one-cycle pulse: free-run
- halt_req  in  1  one-cycle pulse: stop
- step_req  in  1  one-cycle pulse: execute exactly one instruction
- burst_req  in  1  one-cycle pulse: execute burst_len instructions
- burst_len  in  BURST_W  burst length, sampled with burst_req
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- pc  in  32  core's current PC (pc_out)
- cnt_clr  in  1  clear cycle_cnt
- cpu_en  out  1  core clock-enable; the core updates PC/regfile/RAM only on edges where this is 1
- state  out  2  HALTED=0, RUNNING=1, STEP=2, BURST=3
- bp_hit  out  1  sticky: halted by breakpoint
- cycle_cnt  out  CNT_W  count of edges with cpu_en=1

## Operation
- States are HALTED, RUNNING, STEP and BURST. Reset enters HALTED.
- In HALTED, requests are taken with priority halt > step > burst > run. Lower-priority simultaneous requests are dropped.
- HALTED transitions:
  - step_req → STEP
  - burst_req with burst_len≠0 → BURST, remaining counter loaded with burst_len
  - burst_len=0 → request ignored
  - run_req → RUNNING
- Leaving HALTED clears bp_hit.
- In RUNNING, STEP or BURST:
  - halt_req → HALTED
  - run, step and burst requests are ignored
- STEP → HALTED after exactly one enabled edge.
- BURST decrements remaining on each enabled edge. On the edge where remaining goes 1→0, it moves to HALTED.
- Breakpoint:
  - bp_block = bp_en && pc==bp_addr && !skip.
  - skip is set on every exit from HALTED and cleared after the first enabled edge. Resuming at the breakpoint PC therefore executes that instruction once.
  - STEP always skips the breakpoint.
- cpu_en = (state≠HALTED) && !bp_block. It is combinational from registered state, skip and the pc input.
- When bp_block=1 in RUNNING or BURST, the next edge moves to HALTED and sets bp_hit=1. The instruction at bp_addr does not execute.
- cycle_cnt:
  - +1 on every edge with cpu_en=1, wrapping modulo 2^CNT_W
  - cnt_clr has priority over the increment (result 0)

## Timing
- Reset (async, immediate):
  - state=HALTED, cpu_en=0, bp_hit=0, cycle_cnt=0
  - remaining=0, skip=0
- A reset mid-burst or mid-run aborts with no further enabled edge.
- Latency: a request sampled at edge t takes effect at t. cpu_en changes in the cycle after t.
- A step_req pulse gives exactly one cycle of cpu_en=1.
- A burst of N gives exactly N cycles of cpu_en=1, unless cut short by halt_req or a breakpoint.
- halt_req at edge t: the cycle before t keeps its current cpu_en, and cpu_en=0 from t onward.
- Breakpoint: cpu_en drops in the same cycle pc matches (0 cycles latency). state=HALTED one edge later.
- Simultaneous halt_req and final burst edge → HALTED. Both paths agree.
- Simultaneous halt_req and bp_block → HALTED with bp_hit=1.

## Structure
- Shared package holds:
  - the state encodings (HALTED/RUNNING/STEP/BURST)
  - the default CNT_W and BURST_W
- Single module, no sub-module. The breakpoint compare is one line of combinational logic.
- The core top wraps every state-element write enable with cpu_en.

## Test plan
- Reset, then assert rst mid-BURST (remaining=5) → state=0, cpu_en=0 immediately, cycle_cnt=0.
- HALTED, step_req ×3 spaced by 4 cycles → cpu_en high for exactly 3 single cycles, cycle_cnt=3, state returns to 0 after each.
- burst_req with burst_len=7 → 7 consecutive cpu_en cycles, then state=0, cycle_cnt=7. A burst_len=0 request leaves state=0 and cpu_en=0.
- bp_en=1, bp_addr=0x10, run_req from pc=0 (core pc +4 per enabled edge):
  - cpu_en=0 once pc=0x10
  - state=0, bp_hit=1 next edge
  - a new run_req executes 0x10 and continues to 0x14, 0x18…
- Same cycle run_req+step_req+halt_req in HALTED → stays HALTED. step_req+run_req → STEP wins, one enabled cycle.
- RUNNING with halt_req and cnt_clr on the same edge → state=0, cycle_cnt=0. With cycle_cnt preset near 2^CNT_W−1, the count wraps to 0 after the next enabled edge.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the run/halt/step sequencer: state encodings and
// default counter widths.
package exec_ctrl_pkg;

    localparam int DEF_CNT_W   = 32;
    localparam int DEF_BURST_W = 16;

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2,
        ST_BURST   = 2'd3
    } state_t;

endpackage

// File: rtl/exec_ctrl_if.sv
// Debug-side bundle of the execution controller: request pulses, breakpoint
// setup, core PC feedback and the enable/status outputs.
interface exec_ctrl_if
    import exec_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) ();

    logic               run_req;
    logic               halt_req;
    logic               step_req;
    logic               burst_req;
    logic [BURST_W-1:0] burst_len;
    logic               bp_en;
    logic [31:0]        bp_addr;
    logic [31:0]        pc;
    logic               cnt_clr;
    logic               cpu_en;
    state_t             state;
    logic               bp_hit;
    logic [CNT_W-1:0]   cycle_cnt;

    // Debug/bench side: issues requests and observes the core enable.
    modport master (
        output run_req, halt_req, step_req, burst_req, burst_len,
        output bp_en, bp_addr, pc, cnt_clr,
        input  cpu_en, state, bp_hit, cycle_cnt
    );

    // Controller side.
    modport slave (
        input  run_req, halt_req, step_req, burst_req, burst_len,
        input  bp_en, bp_addr, pc, cnt_clr,
        output cpu_en, state, bp_hit, cycle_cnt
    );

endinterface

// File: rtl/exec_ctrl.sv
// Run/halt/step/burst sequencer driving the core clock-enable, with a PC
// breakpoint and a retired-instruction counter.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic        clk,
    input  logic        rst,
    exec_ctrl_if.slave  bus
);

    state_t             state_q, state_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               skip_q, skip_d;
    logic               bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               bp_block;
    logic               cpu_en;

    // skip lets a resume at the breakpoint PC execute that instruction once.
    assign bp_block = bus.bp_en && (bus.pc == bus.bp_addr) && !skip_q;
    assign cpu_en   = (state_q != ST_HALTED) && !bp_block;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        skip_d   = skip_q;
        bp_hit_d = bp_hit_q;

        if (state_q == ST_HALTED) begin
            // Priority halt > step > burst > run; a lone halt keeps us here.
            if (bus.halt_req) begin
                state_d = ST_HALTED;
            end else if (bus.step_req) begin
                state_d  = ST_STEP;
                skip_d   = 1'b1;
                bp_hit_d = 1'b0;
            end else if (bus.burst_req && (bus.burst_len != '0)) begin
                state_d  = ST_BURST;
                rem_d    = bus.burst_len;
                skip_d   = 1'b1;
                bp_hit_d = 1'b0;
            end else if (bus.run_req) begin
                state_d  = ST_RUNNING;
                skip_d   = 1'b1;
                bp_hit_d = 1'b0;
            end
        end else begin
            if (cpu_en) begin
                skip_d = 1'b0;
                if (state_q == ST_BURST) rem_d = rem_q - BURST_W'(1);
            end

            if (bus.halt_req || bp_block) begin
                state_d = ST_HALTED;
                rem_d   = '0;
                if (bp_block) bp_hit_d = 1'b1;
            end else if (state_q == ST_STEP) begin
                state_d = ST_HALTED;
            end else if ((state_q == ST_BURST) && (rem_q == BURST_W'(1))) begin
                state_d = ST_HALTED;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_HALTED;
            rem_q    <= '0;
            skip_q   <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            skip_q   <= skip_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt_q <= '0;
        else if (bus.cnt_clr) cnt_q <= '0;
        else if (cpu_en)      cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.cpu_en    = cpu_en;
    assign bus.state     = state_q;
    assign bus.bp_hit    = bp_hit_q;
    assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed and random stimulus for exec_ctrl, compared against a
// transaction-level model of the run/halt/step/burst rules.
module tb_exec_ctrl;

    localparam int TB_CNT_W   = 8;
    localparam int TB_BURST_W = 16;
    localparam int CNT_MOD    = 1 << TB_CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exec_ctrl_if #(.CNT_W(TB_CNT_W), .BURST_W(TB_BURST_W)) bus ();

    exec_ctrl #(.CNT_W(TB_CNT_W), .BURST_W(TB_BURST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 halted, 1 free-run, 2 single step, 3 burst.
    int m_mode, m_left, m_cnt;
    bit m_skip, m_bp_hit;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_cnt = 0; m_skip = 0; m_bp_hit = 0;
    endtask

    function automatic bit model_en();
        bit at_bp;
        at_bp = bus.bp_en && (bus.pc == bus.bp_addr) && !m_skip;
        return (m_mode != 0) && !at_bp;
    endfunction

    task automatic model_edge(input bit r, h, s, b, input int len, input bit clr, input bit en);
        bit stopped_at_bp;
        if (m_mode == 0) begin
            if (!h && (s || (b && len != 0) || r)) begin
                m_mode   = s ? 2 : ((b && len != 0) ? 3 : 1);
                m_left   = len;
                m_skip   = 1;
                m_bp_hit = 0;
            end
        end else begin
            stopped_at_bp = !en;
            if (en) begin
                m_skip = 0;
                m_left = m_left - 1;
            end
            if (h || stopped_at_bp) begin
                m_mode = 0;
                if (stopped_at_bp) m_bp_hit = 1;
            end else if (m_mode == 2 || (m_mode == 3 && m_left == 0)) begin
                m_mode = 0;
            end
        end
        if (clr)     m_cnt = 0;
        else if (en) m_cnt = (m_cnt + 1) % CNT_MOD;
    endtask

    // One clock: drive pulses (caller is just after a rising edge), check the
    // combinational enable mid-cycle, then check the registered outputs.
    task automatic cyc(input bit r = 0, h = 0, s = 0, b = 0, input int len = 0, input bit clr = 0);
        bit exp_en;
        bus.run_req   = r;
        bus.halt_req  = h;
        bus.step_req  = s;
        bus.burst_req = b;
        bus.burst_len = TB_BURST_W'(len);
        bus.cnt_clr   = clr;
        @(negedge clk);
        exp_en = model_en();
        check("cpu_en", 64'(bus.cpu_en), 64'(exp_en));
        @(posedge clk);
        model_edge(r, h, s, b, len, clr, exp_en);
        #1;
        bus.run_req = 0; bus.halt_req = 0; bus.step_req = 0; bus.burst_req = 0;
        bus.cnt_clr = 0;
        if (exp_en) bus.pc = bus.pc + 32'd4;
        check("state",     64'(bus.state),     64'(m_mode));
        check("bp_hit",    64'(bus.bp_hit),    64'(m_bp_hit));
        check("cycle_cnt", 64'(bus.cycle_cnt), 64'(m_cnt));
    endtask

    initial begin
        bus.run_req = 0; bus.halt_req = 0; bus.step_req = 0; bus.burst_req = 0;
        bus.burst_len = '0; bus.bp_en = 0; bus.bp_addr = '0; bus.pc = '0;
        bus.cnt_clr = 0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_en",    64'(bus.cpu_en), 64'd0);
        check("rst_cnt",   64'(bus.cycle_cnt), 64'd0);

        // Async reset mid-burst with remaining=5.
        cyc(0, 0, 0, 1, 7);
        cyc(); cyc();
        check("burst_mid_en", 64'(bus.cpu_en), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("abort_state", 64'(bus.state), 64'd0);
        check("abort_en",    64'(bus.cpu_en), 64'd0);
        check("abort_cnt",   64'(bus.cycle_cnt), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Three single steps spaced by four cycles.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1);
            check("step_state", 64'(bus.state), 64'd2);
            repeat (3) cyc();
        end
        check("step_cnt", 64'(bus.cycle_cnt), 64'd3);

        // Burst of 7, then a zero-length burst.
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 7);
        repeat (8) cyc();
        check("burst_cnt", 64'(bus.cycle_cnt), 64'd7);
        cyc(0, 0, 0, 1, 0);
        check("burst0_state", 64'(bus.state), 64'd0);
        cyc();

        // Breakpoint at 0x10, run from pc=0, then resume past it.
        bus.pc = 32'h0; bus.bp_en = 1; bus.bp_addr = 32'h10;
        cyc(1);
        repeat (5) cyc();
        check("bp_state", 64'(bus.state), 64'd0);
        check("bp_hit1",  64'(bus.bp_hit), 64'd1);
        check("bp_pc",    64'(bus.pc), 64'h10);
        cyc(1);
        repeat (3) cyc();
        check("resume_pc", 64'(bus.pc), 64'h1C);
        cyc(0, 1);
        bus.bp_en = 0;

        // Simultaneous requests in HALTED.
        cyc(1, 1, 1);
        check("prio_halt", 64'(bus.state), 64'd0);
        cyc(1, 0, 1);
        check("prio_step", 64'(bus.state), 64'd2);
        cyc();

        // Halt with clear, then counter wrap.
        cyc(1);
        repeat (3) cyc();
        cyc(0, 1, 0, 0, 0, 1);
        check("halt_clr_cnt", 64'(bus.cycle_cnt), 64'd0);
        cyc(1);
        repeat (CNT_MOD - 1) cyc();
        check("near_wrap", 64'(bus.cycle_cnt), 64'(CNT_MOD - 1));
        cyc();
        check("wrapped", 64'(bus.cycle_cnt), 64'd0);
        cyc(0, 1);

        // Random requests against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) bus.bp_en = ~bus.bp_en;
            if ($urandom_range(0, 15) == 0) bus.bp_addr = 32'($urandom_range(0, 15)) * 32'd4;
            if (m_mode == 0 && $urandom_range(0, 7) == 0) bus.pc = 32'($urandom_range(0, 15)) * 32'd4;
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 5)), $urandom_range(0, 31) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
